// File: rtl/cpe_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   BUS_W    : data bus width
//   F3_*     : funct3 encodings for load/store size and sign
//   state_e  : controller FSM state encoding
package cpe_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Registered valid/ready data bus between the load/store unit and a memory slave.
//   bus_addr_w_o    : word-aligned address
//   bus_wdata_w_o   : lane-replicated store data
//   bus_be_w_o      : byte enables
//   bus_we_w_o_h    : 1 = write
//   bus_valid_w_o_h : request valid
//   bus_ready_w_i_h : slave accept/complete, read data valid in the same cycle
//   bus_rdata_w_i   : read data
interface data_mem_ctrl_if;
  import cpe_pkg::*;

  logic [BUS_W-1:0] bus_addr_w_o;
  logic [BUS_W-1:0] bus_wdata_w_o;
  logic [3:0]       bus_be_w_o;
  logic             bus_we_w_o_h;
  logic             bus_valid_w_o_h;
  logic             bus_ready_w_i_h;
  logic [BUS_W-1:0] bus_rdata_w_i;

  modport master (
    output bus_addr_w_o,
    output bus_wdata_w_o,
    output bus_be_w_o,
    output bus_we_w_o_h,
    output bus_valid_w_o_h,
    input  bus_ready_w_i_h,
    input  bus_rdata_w_i
  );

  modport slave (
    input  bus_addr_w_o,
    input  bus_wdata_w_o,
    input  bus_be_w_o,
    input  bus_we_w_o_h,
    input  bus_valid_w_o_h,
    output bus_ready_w_i_h,
    output bus_rdata_w_i
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational alignment for the load/store unit.
//   funct3_i  : access size/sign
//   addr_lo_i : byte offset within the word
//   rd_i/wr_i : load/store request
//   st_data_i : store data from the core
//   rdata_i   : read data from the bus
//   be_o      : byte enables (all ones for loads)
//   wdata_o   : store data replicated across lanes
//   ld_data_o : extracted and extended load data
//   illegal_o : access must not be issued
module lsu_align
  import cpe_pkg::*;
(
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       addr_lo_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic [BUS_W-1:0] st_data_i,
  input  logic [BUS_W-1:0] rdata_i,
  output logic [3:0]       be_o,
  output logic [BUS_W-1:0] wdata_o,
  output logic [BUS_W-1:0] ld_data_o,
  output logic             illegal_o
);

  logic       size_h;
  logic       size_w;
  logic       ld_ok;
  logic       st_ok;
  logic [7:0] byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    size_h = (funct3_i[1:0] == 2'b01);
    size_w = (funct3_i[1:0] == 2'b10);
    ld_ok  = funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    st_ok  = funct3_i inside {F3_B, F3_H, F3_W};

    illegal_o = (rd_i & wr_i) | (rd_i & ~ld_ok) | (wr_i & ~st_ok) |
                (size_h & addr_lo_i[0]) | (size_w & (|addr_lo_i));
  end

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    if (wr_i) begin
      unique case (funct3_i[1:0])
        2'b00: begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{st_data_i[7:0]}};
        end
        2'b01: begin
          be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
          wdata_o = {2{st_data_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = st_data_i;
        end
      endcase
    end
  end

  always_comb begin
    unique case (addr_lo_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    unique case (funct3_i)
      F3_B:    ld_data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   ld_data_o = {24'h0, byte_lane};
      F3_H:    ld_data_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   ld_data_o = {16'h0, half_lane};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store unit between the core data-memory port and a valid/ready data bus.
//   clk_w_i, res_w_i_l       : clock, async active-low reset
//   mem_addr_w_i, mem_data_w_i, mem_wr_w_i_h, mem_rd_w_i_h, funct_3_w_i : core request
//   rd_data_w_o              : extended load data, valid in DONE and held after
//   stall_w_o_h              : freezes the core while an access is in flight
//   misalign_w_o_h           : one-cycle pulse for a misaligned/illegal access
//   bus_err_w_o_h            : one-cycle pulse for a bus timeout
//   bus                      : data bus master port
module data_mem_ctrl
  import cpe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                  clk_w_i,
  input  logic                  res_w_i_l,
  input  logic [BUS_W-1:0]      mem_addr_w_i,
  input  logic [BUS_W-1:0]      mem_data_w_i,
  input  logic                  mem_wr_w_i_h,
  input  logic                  mem_rd_w_i_h,
  input  logic [2:0]            funct_3_w_i,
  output logic [BUS_W-1:0]      rd_data_w_o,
  output logic                  stall_w_o_h,
  output logic                  misalign_w_o_h,
  output logic                  bus_err_w_o_h,
  data_mem_ctrl_if.master       bus
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [BUS_W-1:0] addr_q;
  logic [BUS_W-1:0] wdata_q;
  logic [3:0]       be_q;
  logic             we_q;
  logic             valid_q;
  logic [BUS_W-1:0] rd_data_q;
  logic             misalign_q;
  logic             bus_err_q;

  logic             req;
  logic             in_idle;
  logic [2:0]       al_funct3;
  logic [1:0]       al_addr_lo;
  logic             al_rd;
  logic             al_wr;
  logic [3:0]       al_be;
  logic [BUS_W-1:0] al_wdata;
  logic [BUS_W-1:0] al_ld_data;
  logic             al_illegal;

  assign req     = mem_rd_w_i_h | mem_wr_w_i_h;
  assign in_idle = (state_q == StIdle);

  // The aligner sees the live request in IDLE and the captured access afterwards,
  // so load extraction does not depend on the core holding its inputs.
  assign al_funct3  = in_idle ? funct_3_w_i       : f3_q;
  assign al_addr_lo = in_idle ? mem_addr_w_i[1:0] : off_q;
  assign al_rd      = in_idle ? mem_rd_w_i_h      : ~we_q;
  assign al_wr      = in_idle ? mem_wr_w_i_h      : we_q;

  lsu_align u_lsu_align (
    .funct3_i  (al_funct3),
    .addr_lo_i (al_addr_lo),
    .rd_i      (al_rd),
    .wr_i      (al_wr),
    .st_data_i (mem_data_w_i),
    .rdata_i   (bus.bus_rdata_w_i),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .ld_data_o (al_ld_data),
    .illegal_o (al_illegal)
  );

  always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
    if (!res_w_i_l) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      valid_q    <= 1'b0;
      rd_data_q  <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (al_illegal) begin
              state_q    <= StDone;
              misalign_q <= 1'b1;
              rd_data_q  <= '0;
            end else begin
              state_q <= StBus;
              valid_q <= 1'b1;
              we_q    <= mem_wr_w_i_h;
              be_q    <= al_be;
              addr_q  <= {mem_addr_w_i[BUS_W-1:2], 2'b00};
              wdata_q <= mem_wr_w_i_h ? al_wdata : '0;
              f3_q    <= funct_3_w_i;
              off_q   <= mem_addr_w_i[1:0];
              cnt_q   <= '0;
            end
          end
        end
        StBus: begin
          // Ready wins over an expiring timeout in the same cycle.
          if (bus.bus_ready_w_i_h) begin
            valid_q   <= 1'b0;
            rd_data_q <= we_q ? '0 : al_ld_data;
            state_q   <= StDone;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
            valid_q   <= 1'b0;
            rd_data_q <= '0;
            bus_err_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Gated by reset so an abandoned access releases the core immediately.
  assign stall_w_o_h = res_w_i_l & ((in_idle & req) | (state_q == StBus));

  assign rd_data_w_o     = rd_data_q;
  assign misalign_w_o_h  = misalign_q;
  assign bus_err_w_o_h   = bus_err_q;

  assign bus.bus_addr_w_o    = addr_q;
  assign bus.bus_wdata_w_o   = wdata_q;
  assign bus.bus_be_w_o      = be_q;
  assign bus.bus_we_w_o_h    = we_q;
  assign bus.bus_valid_w_o_h = valid_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  import cpe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        mem_wr = 1'b0;
  logic        mem_rd = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] rd_data;
  logic        stall;
  logic        misalign;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk_w_i        (clk),
    .res_w_i_l      (rst_n),
    .mem_addr_w_i   (mem_addr),
    .mem_data_w_i   (mem_data),
    .mem_wr_w_i_h   (mem_wr),
    .mem_rd_w_i_h   (mem_rd),
    .funct_3_w_i    (f3),
    .rd_data_w_o    (rd_data),
    .stall_w_o_h    (stall),
    .misalign_w_o_h (misalign),
    .bus_err_w_o_h  (bus_err),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic issue(input logic rd, input logic wr, input logic [2:0] fn,
                       input logic [31:0] addr, input logic [31:0] data);
    mem_rd   = rd;
    mem_wr   = wr;
    f3       = fn;
    mem_addr = addr;
    mem_data = data;
  endtask

  task automatic drop_req();
    mem_rd = 1'b0;
    mem_wr = 1'b0;
  endtask

  task automatic test_reset();
    bus.bus_ready_w_i_h = 1'b0;
    bus.bus_rdata_w_i   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.bus_valid_w_o_h, bus.bus_we_w_o_h, bus.bus_be_w_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 000000",
               {bus.bus_valid_w_o_h, bus.bus_we_w_o_h, bus.bus_be_w_o});
    end
    checks++;
    if ({bus.bus_addr_w_o, bus.bus_wdata_w_o, rd_data} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0",
               {bus.bus_addr_w_o, bus.bus_wdata_w_o, rd_data});
    end
    checks++;
    if ({misalign, bus_err, stall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {misalign, bus_err, stall});
    end
  endtask

  task automatic test_store_sb();
    bus.bus_ready_w_i_h = 1'b1;
    issue(1'b0, 1'b1, F3_B, 32'h0000_1003, 32'h0000_00A5);
    #1;
    checks++;
    if ({stall, bus.bus_valid_w_o_h} !== 2'b10) begin
      errors++;
      $display("FAIL sb_idle: got %b want 10", {stall, bus.bus_valid_w_o_h});
    end
    @(negedge clk);
    checks++;
    if ({stall, bus.bus_valid_w_o_h, bus.bus_we_w_o_h, bus.bus_be_w_o,
         bus.bus_addr_w_o, bus.bus_wdata_w_o} !== {3'b111, 4'b1000, 32'h1000, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL sb_bus: got %b %b %b %b %h %h want 1 1 1 1000 00001000 a5a5a5a5",
               stall, bus.bus_valid_w_o_h, bus.bus_we_w_o_h, bus.bus_be_w_o,
               bus.bus_addr_w_o, bus.bus_wdata_w_o);
    end
    @(negedge clk);
    checks++;
    if ({stall, bus.bus_valid_w_o_h, misalign, bus_err, rd_data} !== 36'h0) begin
      errors++;
      $display("FAIL sb_done: got stall=%b valid=%b mis=%b err=%b rd=%h want all 0",
               stall, bus.bus_valid_w_o_h, misalign, bus_err, rd_data);
    end
    drop_req();
    @(negedge clk);
  endtask

  task automatic test_loads();
    logic [2:0]  fv [7] = '{F3_B, F3_BU, F3_H, F3_B, F3_HU, F3_H, F3_W};
    logic [31:0] av [7] = '{32'h2002, 32'h2002, 32'h2002, 32'h2001, 32'h2000, 32'h2000,
                            32'h2000};
    logic [31:0] ev [7] = '{32'hFFFFFF80, 32'h00000080, 32'h00001280, 32'hFFFFFFFF,
                            32'h0000FF34, 32'hFFFFFF34, 32'h1280FF34};
    bus.bus_ready_w_i_h = 1'b1;
    bus.bus_rdata_w_i   = 32'h1280FF34;
    for (int i = 0; i < 7; i++) begin
      issue(1'b1, 1'b0, fv[i], av[i], 32'hCAFEF00D);
      #1;
      checks++;
      if ({stall, bus.bus_valid_w_o_h} !== 2'b10) begin
        errors++;
        $display("FAIL ld%0d_idle: got %b want 10", i, {stall, bus.bus_valid_w_o_h});
      end
      @(negedge clk);
      checks++;
      if ({stall, bus.bus_valid_w_o_h, bus.bus_we_w_o_h, bus.bus_be_w_o, bus.bus_addr_w_o}
          !== {3'b110, 4'b1111, av[i][31:2], 2'b00}) begin
        errors++;
        $display("FAIL ld%0d_bus: got %b %b %b %b %h want 1 1 0 1111 %h", i, stall,
                 bus.bus_valid_w_o_h, bus.bus_we_w_o_h, bus.bus_be_w_o, bus.bus_addr_w_o,
                 {av[i][31:2], 2'b00});
      end
      @(negedge clk);
      checks++;
      if ({stall, bus.bus_valid_w_o_h, rd_data} !== {2'b00, ev[i]}) begin
        errors++;
        $display("FAIL ld%0d_data: got stall=%b valid=%b rd=%h want 0 0 %h", i, stall,
                 bus.bus_valid_w_o_h, rd_data, ev[i]);
      end
      drop_req();
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic        rv [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        wv [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  fv [6] = '{F3_W, 3'b011, F3_B, F3_H, 3'b100, F3_HU};
    logic [31:0] av [6] = '{32'h3002, 32'h3000, 32'h3000, 32'h3001, 32'h3000, 32'h3003};
    bus.bus_ready_w_i_h = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(rv[i], wv[i], fv[i], av[i], 32'h1111_2222);
      #1;
      checks++;
      if ({stall, bus.bus_valid_w_o_h, misalign} !== 3'b100) begin
        errors++;
        $display("FAIL ill%0d_idle: got %b want 100", i, {stall, bus.bus_valid_w_o_h, misalign});
      end
      @(negedge clk);
      checks++;
      if ({stall, bus.bus_valid_w_o_h, misalign, bus_err, rd_data} !== {4'b0010, 32'h0}) begin
        errors++;
        $display("FAIL ill%0d_done: got stall=%b valid=%b mis=%b err=%b rd=%h want 0 0 1 0 0",
                 i, stall, bus.bus_valid_w_o_h, misalign, bus_err, rd_data);
      end
      drop_req();
      @(negedge clk);
      checks++;
      if ({stall, bus.bus_valid_w_o_h, misalign} !== 3'b000) begin
        errors++;
        $display("FAIL ill%0d_after: got %b want 000", i, {stall, bus.bus_valid_w_o_h, misalign});
      end
    end
  endtask

  task automatic test_delayed_ready();
    int xfers = 0;
    bus.bus_ready_w_i_h = 1'b0;
    bus.bus_rdata_w_i   = 32'hDEADBEEF;
    issue(1'b1, 1'b0, F3_W, 32'h0000_5004, 32'h0);
    #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({stall, bus.bus_valid_w_o_h, bus.bus_we_w_o_h, bus.bus_be_w_o, bus.bus_addr_w_o,
           bus.bus_wdata_w_o} !== {3'b110, 4'b1111, 32'h5004, 32'h0}) begin
        errors++;
        $display("FAIL dly%0d_hold: got %b %b %b %b %h %h want 1 1 0 1111 00005004 0", k,
                 stall, bus.bus_valid_w_o_h, bus.bus_we_w_o_h, bus.bus_be_w_o,
                 bus.bus_addr_w_o, bus.bus_wdata_w_o);
      end
      if (k == 3) bus.bus_ready_w_i_h = 1'b1;
      if (bus.bus_valid_w_o_h && bus.bus_ready_w_i_h) xfers++;
    end
    @(negedge clk);
    bus.bus_ready_w_i_h = 1'b0;
    checks++;
    if ({stall, bus.bus_valid_w_o_h, bus_err, rd_data} !== {3'b000, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL dly_done: got stall=%b valid=%b err=%b rd=%h want 0 0 0 deadbeef",
               stall, bus.bus_valid_w_o_h, bus_err, rd_data);
    end
    drop_req();
    @(negedge clk);
    if (bus.bus_valid_w_o_h) xfers++;
    checks++;
    if (xfers !== 1) begin
      errors++;
      $display("FAIL dly_xfers: got %0d want 1", xfers);
    end
  endtask

  task automatic test_timeout();
    bus.bus_ready_w_i_h = 1'b0;
    issue(1'b1, 1'b0, F3_W, 32'h0000_4000, 32'h0);
    #1;
    checks++;
    if ({stall, bus.bus_valid_w_o_h} !== 2'b10) begin
      errors++;
      $display("FAIL to_idle: got %b want 10", {stall, bus.bus_valid_w_o_h});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({stall, bus.bus_valid_w_o_h, bus_err} !== 3'b110) begin
        errors++;
        $display("FAIL to_wait%0d: got %b want 110", k, {stall, bus.bus_valid_w_o_h, bus_err});
      end
    end
    @(negedge clk);
    checks++;
    if ({stall, bus.bus_valid_w_o_h, bus_err, misalign, rd_data} !== {4'b0010, 32'h0}) begin
      errors++;
      $display("FAIL to_done: got stall=%b valid=%b err=%b mis=%b rd=%h want 0 0 1 0 0",
               stall, bus.bus_valid_w_o_h, bus_err, misalign, rd_data);
    end
    drop_req();
    @(negedge clk);
    checks++;
    if ({stall, bus.bus_valid_w_o_h, bus_err} !== 3'b000) begin
      errors++;
      $display("FAIL to_after: got %b want 000", {stall, bus.bus_valid_w_o_h, bus_err});
    end
    // Back in IDLE: a new request must stall again.
    issue(1'b1, 1'b0, F3_W, 32'h0000_4000, 32'h0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL to_reidle: got stall=%b want 1", stall);
    end
    drop_req();
    #1;
  endtask

  task automatic test_reset_mid_bus();
    bus.bus_ready_w_i_h = 1'b0;
    @(negedge clk);
    issue(1'b0, 1'b1, F3_W, 32'h0000_6000, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if ({bus.bus_valid_w_o_h, bus.bus_wdata_w_o} !== {1'b1, 32'h12345678}) begin
      errors++;
      $display("FAIL rst_pre: got valid=%b wdata=%h want 1 12345678",
               bus.bus_valid_w_o_h, bus.bus_wdata_w_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.bus_valid_w_o_h, stall} !== 2'b00) begin
      errors++;
      $display("FAIL rst_async: got valid=%b stall=%b want 0 0", bus.bus_valid_w_o_h, stall);
    end
    drop_req();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.bus_valid_w_o_h, bus.bus_we_w_o_h, bus.bus_be_w_o, bus.bus_addr_w_o,
         bus.bus_wdata_w_o, rd_data, misalign, bus_err, stall} !== 105'h0) begin
      errors++;
      $display("FAIL rst_after: got %b %b %b %h %h %h %b %b %b want all 0",
               bus.bus_valid_w_o_h, bus.bus_we_w_o_h, bus.bus_be_w_o, bus.bus_addr_w_o,
               bus.bus_wdata_w_o, rd_data, misalign, bus_err, stall);
    end
  endtask

  initial begin
    test_reset();
    test_store_sb();
    test_loads();
    test_illegal();
    test_delayed_ready();
    test_timeout();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
